metropolis_accept_unit: RTL

METROPOLIS_ACCEPT_UNIT -- requirements
Module: metropolis_accept_unit

---
 rtl/metropolis_accept_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/metropolis_accept_unit.sv
// Metropolis accept/reject unit: compares a proposed energy with the current energy
// using a temperature-scaled threshold. Optional statistics counters: METROPOLIS_ACCEPT_STATS_EN.
module metropolis_accept_unit #(
  parameter int unsigned ENERGY_WIDTH = 8,
  parameter int unsigned U_WIDTH      = 16
) (
  input  logic                    in_clk,
  input  logic                    in_reset,
  input  logic                    in_catch_U,
  input  logic [U_WIDTH-1:0]      in_random,
  input  logic                    in_load_energy,
  input  logic                    in_compute_for_proposed_value,
  input  logic [ENERGY_WIDTH-1:0] in_energy,
  input  logic                    in_calculate_probability_enable,
  input  logic [2:0]              in_temp_shift,
  output logic                    out_decision_valid,
  output logic                    out_accept,
  output logic [ENERGY_WIDTH-1:0] out_current_energy,
  output logic                    out_sequence_error,
  output logic [1:0]              out_state
`ifdef METROPOLIS_ACCEPT_STATS_EN
  ,
  output logic [15:0]             out_accept_count,
  output logic [15:0]             out_reject_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PROPOSED = 2'd1,
    DECIDE   = 2'd2,
    RESULT   = 2'd3
  } state_t;

  state_t                  state;
  logic [U_WIDTH-1:0]      u_q;
  logic [ENERGY_WIDTH-1:0] proposed_q;
  logic [2:0]              temp_q;

  logic [ENERGY_WIDTH-1:0] delta_c;
  logic [ENERGY_WIDTH-1:0] shift_c;
  logic [U_WIDTH-1:0]      thresh_c;
  logic                    accept_c;

  assign out_state = 2'(state);

  // Acceptance threshold shrinks by half for every unit of scaled energy increase.
  always_comb begin
    delta_c  = '0;
    thresh_c = '0;
    if (proposed_q > out_current_energy) begin
      delta_c = proposed_q - out_current_energy;
    end
    shift_c = delta_c >> temp_q;
    if (32'(shift_c) < U_WIDTH) begin
      thresh_c = {U_WIDTH{1'b1}} >> shift_c;
    end
    accept_c = (proposed_q <= out_current_energy) || (shift_c == '0) || (u_q < thresh_c);
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state              <= IDLE;
      u_q                <= '0;
      proposed_q         <= '0;
      temp_q             <= '0;
      out_current_energy <= '0;
      out_accept         <= 1'b0;
      out_decision_valid <= 1'b0;
      out_sequence_error <= 1'b0;
`ifdef METROPOLIS_ACCEPT_STATS_EN
      out_accept_count   <= '0;
      out_reject_count   <= '0;
`endif
    end else begin
      out_decision_valid <= 1'b0;
      if (in_catch_U) begin
        u_q <= in_random;
      end
      case (state)
        IDLE: begin
          if (in_compute_for_proposed_value) begin
            proposed_q <= in_energy;
            state      <= PROPOSED;
          end else if (in_load_energy) begin
            out_current_energy <= in_energy;
          end
          if (in_calculate_probability_enable) begin
            out_sequence_error <= 1'b1;
          end
        end
        PROPOSED: begin
          if (in_compute_for_proposed_value) begin
            proposed_q <= in_energy;
          end else if (in_calculate_probability_enable) begin
            temp_q <= in_temp_shift;
            state  <= DECIDE;
          end
        end
        DECIDE: begin
          out_accept         <= accept_c;
          out_decision_valid <= 1'b1;
          state              <= RESULT;
        end
        RESULT: begin
          if (out_accept) begin
            out_current_energy <= proposed_q;
          end
`ifdef METROPOLIS_ACCEPT_STATS_EN
          if (out_accept) begin
            if (out_accept_count != 16'hFFFF) out_accept_count <= out_accept_count + 16'd1;
          end else begin
            if (out_reject_count != 16'hFFFF) out_reject_count <= out_reject_count + 16'd1;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
